// File: rtl/rob_core.sv
// Reorder buffer core: in-order retirement of out-of-order writebacks.
// Entries are allocated at the tail and marked ready by result writebacks.
// Each cycle, at most one entry retires from the head, and only once it is ready.
// Optional feature: define ROB_FWD_EN to build the q1/q2 operand lookup port.
// With ROB_FWD_EN undefined, q*_ready and q*_value are tied to 0.
module rob_core #(
  parameter int ROB_WIDTH_BIT = 3,
  parameter int REG_ID_BIT    = 5
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     alloc_en,
  input  logic [REG_ID_BIT-1:0]    alloc_reg,
  output logic [ROB_WIDTH_BIT-1:0] alloc_id,
  output logic                     full,
  input  logic                     wb_en,
  input  logic [ROB_WIDTH_BIT-1:0] wb_id,
  input  logic [31:0]              wb_value,
  output logic                     commit_en,
  output logic [REG_ID_BIT-1:0]    commit_reg,
  output logic [ROB_WIDTH_BIT-1:0] commit_id,
  output logic [31:0]              commit_value,
  input  logic [ROB_WIDTH_BIT-1:0] q1_id,
  input  logic [ROB_WIDTH_BIT-1:0] q2_id,
  output logic                     q1_ready,
  output logic                     q2_ready,
  output logic [31:0]              q1_value,
  output logic [31:0]              q2_value
);

  localparam int DEPTH = 1 << ROB_WIDTH_BIT;
  localparam logic [ROB_WIDTH_BIT:0]   CNT_FULL = (ROB_WIDTH_BIT+1)'(DEPTH);
  localparam logic [ROB_WIDTH_BIT:0]   CNT_ONE  = (ROB_WIDTH_BIT+1)'(1);
  localparam logic [ROB_WIDTH_BIT-1:0] PTR_ONE  = ROB_WIDTH_BIT'(1);

  logic [DEPTH-1:0]         busy;
  logic [DEPTH-1:0]         ready;
  logic [REG_ID_BIT-1:0]    dest  [DEPTH];
  logic [31:0]              value [DEPTH];
  logic [ROB_WIDTH_BIT-1:0] head;
  logic [ROB_WIDTH_BIT-1:0] tail;
  logic [ROB_WIDTH_BIT:0]   count;

  logic do_commit;
  logic do_alloc;
  logic do_wb;

  assign full     = (count == CNT_FULL);
  assign alloc_id = tail;

  // Decode this cycle's actions; flush and pause suppress all of them.
  // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    do_commit = 1'b0;
    do_alloc  = 1'b0;
    do_wb     = 1'b0;
    if (rdy_in && !flush_in) begin
      do_commit = busy[head] && ready[head];
      // Full is judged on the current count, so a same-cycle commit never frees a slot early.
      do_alloc  = alloc_en && !full;
      // A writeback to the entry retiring this edge is dropped, so the two never overlap.
      do_wb     = wb_en && busy[wb_id] && !(do_commit && (wb_id == head));
    end
  end

  // Pointers, occupancy count, and per-entry status flags.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      ready <= '0;
    end else if (flush_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      ready <= '0;
    end else if (rdy_in) begin
      if (do_commit) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
        head        <= head + PTR_ONE;
      end
      if (do_wb) begin
        ready[wb_id] <= 1'b1;
      end
      if (do_alloc) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= tail + PTR_ONE;
      end
      case ({do_alloc, do_commit})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry payload: destination register and result value.
  // NOTE: payload storage has no reset; it is only read while the busy/ready flags, which are reset, qualify it.
  always_ff @(posedge clk_in) begin
    if (do_alloc) begin
      dest[tail] <= alloc_reg;
    end
    if (do_wb) begin
      value[wb_id] <= wb_value;
    end
  end

  // Registered regfile write port; an x0 destination retires silently.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      commit_en    <= 1'b0;
      commit_reg   <= '0;
      commit_id    <= '0;
      commit_value <= '0;
    end else begin
      commit_en <= 1'b0;
      if (do_commit) begin
        commit_en    <= (dest[head] != '0);
        commit_reg   <= dest[head];
        commit_id    <= head;
        commit_value <= value[head];
      end
    end
  end

`ifdef ROB_FWD_EN
  // Operand lookup: a value is forwarded only once its entry holds a result.
  always_comb begin
    q1_ready = busy[q1_id] && ready[q1_id];
    q2_ready = busy[q2_id] && ready[q2_id];
    q1_value = '0;
    q2_value = '0;
    if (q1_ready) q1_value = value[q1_id];
    if (q2_ready) q2_value = value[q2_id];
  end
`else
  logic unused_q_ids;
  assign unused_q_ids = ^{q1_id, q2_id};
  assign q1_ready = 1'b0;
  assign q2_ready = 1'b0;
  assign q1_value = '0;
  assign q2_value = '0;
`endif

endmodule

// File: doc/rob_core.md
ROB_CORE -- requirements
Module: rob_core

Interface
REQ-001 The block SHALL have parameter ROB_WIDTH_BIT, default 3, meaning the log2 of the entry count (8 entries).
REQ-002 The block SHALL have parameter REG_ID_BIT, default 5, meaning the architectural register index width.
REQ-003 The block SHALL have port clk_in, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_in, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port rdy_in, input, 1, pause when low.
REQ-006 The block SHALL have port flush_in, input, 1, discard all entries.
REQ-007 The block SHALL have port alloc_en, input, 1, decoder requests an entry.
REQ-008 The block SHALL have port alloc_reg, input, REG_ID_BIT, destination register of the new entry.
REQ-009 The block SHALL have port alloc_id, output, ROB_WIDTH_BIT, tail index granted to the new entry (combinational).
REQ-010 The block SHALL have port full, output, 1, no free entry (combinational from count).
REQ-011 The block SHALL have ports wb_en (input, 1), wb_id (input, ROB_WIDTH_BIT) and wb_value (input, 32), the result broadcast marking entry wb_id ready.
REQ-012 The block SHALL have ports commit_en (output, 1), commit_reg (output, REG_ID_BIT), commit_id (output, ROB_WIDTH_BIT) and commit_value (output, 32), all registered, forming the regfile write port.
REQ-013 The block SHALL have ports q1_id and q2_id (input, ROB_WIDTH_BIT), q1_ready and q2_ready (output, 1), and q1_value and q2_value (output, 32), the operand lookup for the decoder.

Function
REQ-014 The block SHALL hold, per entry, busy, ready, dest reg and 32-bit value, with head, tail and a count of ROB_WIDTH_BIT+1 bits.
REQ-015 The block SHALL set full exactly when count equals 2^ROB_WIDTH_BIT, and SHALL drive alloc_id equal to tail.
REQ-016 On alloc_en with full low, the block SHALL set entry[tail] to busy=1, ready=0, dest=alloc_reg, advance tail by 1 mod 2^ROB_WIDTH_BIT, and increment count.
REQ-017 The block SHALL ignore alloc_en while full is high, even if a commit occurs in the same cycle.
REQ-018 On wb_en with entry[wb_id].busy set, the block SHALL set ready=1 and value=wb_value; a writeback to a non-busy entry SHALL be ignored.
REQ-019 When entry[head] is busy and ready at a rising edge, the block SHALL, at that edge, pulse commit_en for one cycle with commit_id=head, commit_reg=dest, commit_value=value, clear busy, advance head, and decrement count.
REQ-020 The block SHALL commit at most one entry per cycle.
REQ-021 The earliest commit SHALL be one edge after the writeback edge, and a writeback and a commit of the same entry SHALL never occur in the same cycle.
REQ-022 An entry whose dest is 0 SHALL retire normally but with commit_en held low.
REQ-023 When alloc and commit occur in the same cycle, count SHALL remain unchanged, and both head and tail SHALL advance.
REQ-024 Head and tail SHALL wrap from 2^ROB_WIDTH_BIT-1 to 0.
REQ-025 flush_in SHALL take priority over alloc, writeback and commit: it clears all busy and ready bits, sets head, tail and count to 0, and drives commit_en to 0 on that edge.
REQ-026 While rdy_in is low, the block SHALL hold all state and SHALL drive commit_en to 0.

Reset
REQ-027 Asserting rst_in low SHALL immediately clear head, tail, count and all busy and ready bits, and drive commit_en, commit_reg, commit_id and commit_value to 0, including in the middle of a commit.
REQ-028 After reset, full SHALL be 0 and alloc_id SHALL be 0.
REQ-029 Deasserting rst_in SHALL take effect at the next rising edge of clk_in.

Configuration
REQ-030 With macro ROB_FWD_EN defined, q*_ready SHALL equal entry[q*_id].busy AND ready, and q*_value SHALL equal entry[q*_id].value when ready, else 0, combinationally.
REQ-031 With ROB_FWD_EN not defined, q*_ready and q*_value SHALL be constant 0, and no lookup logic SHALL be built.

Verification
REQ-032 Reset, then 8 allocs with dests 1..8 -> alloc_id 0..7, full=1 after the 8th; a 9th alloc is ignored and tail stays 0.
REQ-033 Alloc id0 (dest 5), wb id0 value 0xDEADBEEF at edge E -> at edge E+1 commit_en=1, commit_reg=5, commit_id=0, commit_value=0xDEADBEEF for one cycle.
REQ-034 Out-of-order writeback: wb id2, then id1, then id0 -> commits occur in order 0, 1, 2 on consecutive cycles.
REQ-035 Full buffer with head ready, plus alloc in the same cycle -> the commit occurs, the alloc is rejected, and count becomes 7.
REQ-036 Flush with 5 entries in flight -> count=0 and commit_en=0, and a following alloc returns alloc_id=0.
REQ-037 With ROB_FWD_EN defined, wb id3 value 0x42, then q1_id=3 -> q1_ready=1 and q1_value=0x42; with id3 not ready -> q1_ready=0 and q1_value=0.
